regfile_access_ctrl: RTL and testbench

Command-driven sequencer that is the initiator side of the 8-bit register file port (`w`, `rw`, `wsel`, `rsel`, `read0`, `read1`). It accepts one write or read command at a time over a valid/ready handshake and drives the register-file control lines with correct timing. It then waits the register file's read latency, captures `read0`/`read1`, and returns one response per command over a second valid/ready handshake. It sits between the datapath's control logic and `registerfile`, and is the only block that drives the register-file control lines.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_wait_cnt.sv | 43 ++++
 rtl/regfile_access_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file access controller:
//   - DATA_W_DEFAULT : default register width
//   - READ_LAT_MAX   : largest read latency the wait counter can hold
//   - CNT_W          : width of the read-latency wait counter
//   - state_e        : controller state encoding (VERIFY exists only when
//                      REGFILE_CTRL_VERIFY_EN is defined)
package regfile_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned READ_LAT_MAX   = 15;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_WAIT = 3'd2,
        ST_RESP      = 3'd3
`ifdef REGFILE_CTRL_VERIFY_EN
        ,
        ST_VERIFY    = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/regfile_wait_cnt.sv
// regfile_wait_cnt
// Loadable 4-bit down-counter that times the register-file read latency.
// It stops at zero and reports it through a flag.
//   sysclk   : clock, rising edge
//   reset    : synchronous, active-high; clears the count
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one when the count is non-zero
//   zero     : count is zero
module regfile_wait_cnt
    import regfile_pkg::*;
(
    input  logic             sysclk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Initiator-side sequencer for the register-file port. It accepts one
// read or write command at a time and drives the register-file control
// lines. For reads it waits READ_LAT cycles and captures read0/read1. It
// returns exactly one response per command. All outputs are registered.
//
// Optional feature: when the macro REGFILE_CTRL_VERIFY_EN is defined, each
// write is read back through read0. rsp_err then flags a mismatch against
// the written data. Without the macro, rsp_err is tied to 0.
//
// Ports:
//   sysclk, reset            : clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_write                : 1 = write, 0 = read
//   cmd_wsel, cmd_rsel       : write target / read select
//   cmd_data                 : write data
//   rsp_valid/rsp_ready      : response handshake
//   rsp_read0, rsp_read1     : captured read data
//   rsp_err                  : write-verify mismatch
//   rf_w, rf_rw, rf_wsel,
//   rf_rsel                  : register-file control lines
//   rf_read0, rf_read1       : register-file read data
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_wsel,
    input  logic [1:0]        cmd_rsel,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_read0,
    output logic [DATA_W-1:0] rsp_read1,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rf_w,
    output logic              rf_rw,
    output logic              rf_wsel,
    output logic [1:0]        rf_rsel,
    input  logic [DATA_W-1:0] rf_read0,
    input  logic [DATA_W-1:0] rf_read1
);

    // Latencies beyond what the 4-bit counter can hold are clamped.
    localparam logic [CNT_W-1:0] LAT_LOAD =
        (READ_LAT > READ_LAT_MAX) ? CNT_W'(READ_LAT_MAX) : CNT_W'(READ_LAT);

    state_e state_q, state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_read0_q, rsp_read0_d;
    logic [DATA_W-1:0] rsp_read1_q, rsp_read1_d;
    logic [DATA_W-1:0] rf_w_q, rf_w_d;
    logic              rf_rw_q, rf_rw_d;
    logic              rf_wsel_q, rf_wsel_d;
    logic [1:0]        rf_rsel_q, rf_rsel_d;
`ifdef REGFILE_CTRL_VERIFY_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    logic accept;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

    // The wait counter is shared by the read wait and the write verify.
    always_comb begin
        cnt_load = accept && !cmd_write;
        cnt_dec  = (state_q == ST_READ_WAIT);
`ifdef REGFILE_CTRL_VERIFY_EN
        cnt_load = cnt_load || (state_q == ST_WRITE);
        cnt_dec  = cnt_dec  || (state_q == ST_VERIFY);
`endif
    end

    regfile_wait_cnt u_wait_cnt (
        .sysclk   (sysclk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = cmd_write ? ST_WRITE : ST_READ_WAIT;
                end
            end
            ST_WRITE: begin
`ifdef REGFILE_CTRL_VERIFY_EN
                state_d = ST_VERIFY;
`else
                state_d = ST_RESP;
`endif
            end
            ST_READ_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end
            end
`ifdef REGFILE_CTRL_VERIFY_EN
            ST_VERIFY: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: all outputs are registered. The handshake flags follow
    // the next state, so each flag is asserted in the same cycle the FSM
    // enters the matching state.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rf_rw_d     = (state_d == ST_WRITE);
        rsp_read0_d = rsp_read0_q;
        rsp_read1_d = rsp_read1_q;
        rf_w_d      = rf_w_q;
        rf_wsel_d   = rf_wsel_q;
        rf_rsel_d   = rf_rsel_q;
`ifdef REGFILE_CTRL_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif

        // rf_w/rf_wsel double as the latched write command. rf_rsel doubles
        // as the latched read select. Each only changes when it is in use.
        if (accept) begin
            if (cmd_write) begin
                rf_w_d    = cmd_data;
                rf_wsel_d = cmd_wsel;
            end else begin
                rf_rsel_d = cmd_rsel;
            end
        end

        case (state_q)
            ST_WRITE: begin
`ifdef REGFILE_CTRL_VERIFY_EN
                rf_rsel_d   = {1'b0, rf_wsel_q};
`else
                rsp_read0_d = '0;
                rsp_read1_d = '0;
`endif
            end
            ST_READ_WAIT: begin
                if (cnt_zero) begin
                    rsp_read0_d = rf_read0;
                    rsp_read1_d = rf_read1;
`ifdef REGFILE_CTRL_VERIFY_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
`ifdef REGFILE_CTRL_VERIFY_EN
            ST_VERIFY: begin
                if (cnt_zero) begin
                    rsp_read0_d = rf_read0;
                    rsp_read1_d = rf_read1;
                    rsp_err_d   = (rf_read0 != rf_w_q);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_read0_q <= '0;
            rsp_read1_q <= '0;
            rf_w_q      <= '0;
            rf_rw_q     <= 1'b0;
            rf_wsel_q   <= 1'b0;
            rf_rsel_q   <= '0;
`ifdef REGFILE_CTRL_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_read0_q <= rsp_read0_d;
            rsp_read1_q <= rsp_read1_d;
            rf_w_q      <= rf_w_d;
            rf_rw_q     <= rf_rw_d;
            rf_wsel_q   <= rf_wsel_d;
            rf_rsel_q   <= rf_rsel_d;
`ifdef REGFILE_CTRL_VERIFY_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_read0 = rsp_read0_q;
    assign rsp_read1 = rsp_read1_q;
    assign rf_w      = rf_w_q;
    assign rf_rw     = rf_rw_q;
    assign rf_wsel   = rf_wsel_q;
    assign rf_rsel   = rf_rsel_q;
`ifdef REGFILE_CTRL_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl with a behavioural two-entry register
// file that has a LAT-cycle read latency. Expected responses are queued at
// issue time. A monitor compares them whenever rsp_valid is seen.
module tb_regfile_access_ctrl;

    localparam int unsigned LAT = 2;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_wsel;
    logic [1:0] cmd_rsel;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_read0, rsp_read1;
    logic [7:0] rf_w;
    logic       rf_rw, rf_wsel;
    logic [1:0] rf_rsel;
    logic [7:0] rf_read0, rf_read1;

    always #5 sysclk = ~sysclk;

    regfile_access_ctrl #(.DATA_W(8), .READ_LAT(LAT)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_wsel  (cmd_wsel),
        .cmd_rsel  (cmd_rsel),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_read0 (rsp_read0),
        .rsp_read1 (rsp_read1),
        .rsp_err   (rsp_err),
        .rf_w      (rf_w),
        .rf_rw     (rf_rw),
        .rf_wsel   (rf_wsel),
        .rf_rsel   (rf_rsel),
        .rf_read0  (rf_read0),
        .rf_read1  (rf_read1)
    );

    // ---------------- register file model ----------------
    logic [7:0]  rf_mem [2];
    logic [7:0]  init0, init1;
    logic        tb_init = 1'b1;
    logic [15:0] pipe0;
    logic [15:0] pipe [1:LAT];
    bit          corrupt = 1'b0;

    always @(posedge sysclk) begin
        if (tb_init) begin
            rf_mem[0] <= init0;
            rf_mem[1] <= init1;
        end else if (rf_rw) begin
            rf_mem[rf_wsel] <= rf_w;
        end
        pipe[1] <= pipe0;
        for (int i = 2; i <= LAT; i++) pipe[i] <= pipe[i-1];
    end

    always_comb pipe0 = {rf_mem[rf_rsel[1]], rf_mem[rf_rsel[0]]};

`ifdef REGFILE_CTRL_VERIFY_EN
    assign rf_read0 = corrupt ? 8'h00 : pipe[LAT][7:0];
`else
    assign rf_read0 = pipe[LAT][7:0];
`endif
    assign rf_read1 = pipe[LAT][15:8];

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic        err;
        int unsigned rise;
    } exp_t;

    exp_t        exp_q [$];
    logic [7:0]  shadow [2];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          hold_low = 1'b0;
    bit          ready_random = 1'b0;
    bit          prev_valid = 1'b0;

    always @(posedge sysclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // rsp_ready changes away from both clock edges
    always @(posedge sysclk) begin
        #1;
        if (hold_low)          rsp_ready = 1'b0;
        else if (ready_random) rsp_ready = 1'($urandom_range(0, 1));
        else                   rsp_ready = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge sysclk) begin
        exp_t e;
        if (reset === 1'b1) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got response with no command outstanding (cycle %0d)", cyc);
                end else begin
                    e = exp_q[0];
                    check("rsp_read0", rsp_read0, e.r0);
                    check("rsp_read1", rsp_read1, e.r1);
                    check("rsp_err", rsp_err, e.err);
                    check("cmd_ready_in_resp", cmd_ready, 0);
                    if (!prev_valid) check("rsp_rise_cycle", cyc, e.rise);
                    if (rsp_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
            prev_valid = (rsp_valid === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic wr, input logic ws, input logic [1:0] rs, input logic [7:0] d);
        exp_t        e;
        int unsigned waited = 0;
        int unsigned a;
        @(negedge sysclk);
        while (cmd_ready !== 1'b1 && waited < 300) begin
            @(negedge sysclk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: cmd_ready=%b, required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_wsel  = ws;
        cmd_rsel  = rs;
        cmd_data  = d;
        a = cyc + 1;  // cycle-count value during cycle 1 after the accept edge
        if (wr) begin
            shadow[ws] = d;
`ifdef REGFILE_CTRL_VERIFY_EN
            e.r0   = corrupt ? 8'h00 : d;
            e.r1   = shadow[0];
            e.err  = corrupt;
            e.rise = a + 2 + LAT;
`else
            e.r0   = 8'h00;
            e.r1   = 8'h00;
            e.err  = 1'b0;
            e.rise = a + 1;
`endif
        end else begin
            e.r0   = shadow[rs[0]];
            e.r1   = shadow[rs[1]];
            e.err  = 1'b0;
            e.rise = a + 1 + LAT;
        end
        exp_q.push_back(e);
        @(negedge sysclk);
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 0);
        if (wr) begin
            check("rf_rw_cycle1", rf_rw, 1);
            check("rf_w", rf_w, d);
            check("rf_wsel", rf_wsel, ws);
            @(negedge sysclk);
            check("rf_rw_cycle2", rf_rw, 0);
`ifdef REGFILE_CTRL_VERIFY_EN
            check("rf_rsel_verify", rf_rsel, {1'b0, ws});
`endif
        end else begin
            for (int i = 0; i <= int'(LAT); i++) begin
                check("rf_rsel_read", rf_rsel, rs);
                check("rf_rw_read", rf_rw, 0);
                @(negedge sysclk);
            end
        end
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge sysclk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init0     = 8'($urandom);
        init1     = 8'($urandom);
        shadow[0] = init0;
        shadow[1] = init1;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_wsel  = 1'b0;
        cmd_rsel  = 2'b00;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;

        // reset held 3 cycles
        @(negedge sysclk);
        check("reset_outputs", {cmd_ready, rsp_valid, rsp_read0, rsp_read1, rsp_err,
                                rf_w, rf_rw, rf_wsel, rf_rsel}, 0);
        @(negedge sysclk);
        @(negedge sysclk);
        check("reset_outputs_end", {cmd_ready, rsp_valid, rsp_read0, rsp_read1, rsp_err,
                                    rf_w, rf_rw, rf_wsel, rf_rsel}, 0);
        reset   = 1'b0;
        tb_init = 1'b0;
        @(negedge sysclk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        // directed write and read
        issue(1'b1, 1'b1, 2'b00, 8'hFF);
        wait_drain();
        issue(1'b0, 1'b0, 2'b01, 8'h00);
        wait_drain();

        // read with the consumer stalling for 5 cycles
        hold_low = 1'b1;
        issue(1'b0, 1'b0, 2'b10, 8'h00);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_rsel  = 2'b11;
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_cmd_ready", cmd_ready, 0);
            @(negedge sysclk);
        end
        cmd_valid = 1'b0;
        hold_low  = 1'b0;
        wait_drain();

`ifdef REGFILE_CTRL_VERIFY_EN
        // write whose read-back is corrupted
        corrupt = 1'b1;
        issue(1'b1, 1'b0, 2'b00, 8'hA5);
        wait_drain();
        corrupt = 1'b0;
`endif

        // reset during READ_WAIT abandons the command
        @(negedge sysclk);
        while (cmd_ready !== 1'b1) @(negedge sysclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_rsel  = 2'b11;
        @(negedge sysclk);
        cmd_valid = 1'b0;
        check("abort_rsel", rf_rsel, 2'b11);
        reset = 1'b1;
        @(negedge sysclk);
        check("abort_rf_rw", rf_rw, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        check("abort_cmd_ready_after", cmd_ready, 1);
        check("abort_no_rsp", rsp_valid, 0);
        repeat (LAT + 4) @(negedge sysclk);

        // randomized traffic with a randomly stalling consumer
        ready_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom));
        end
        ready_random = 1'b0;
        wait_drain();
        repeat (3) @(negedge sysclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
